seq_det_ctrl: RTL and testbench
===============================

# seq_det_ctrl

Controller that configures and sequences a programmable serial pattern detector for the sequence-detector lab designs. It latches a pattern and mode on a start handshake and qualifies the serial input with a valid strobe. It counts pattern matches, in overlapping or non-overlapping mode, and signals completion once a programmed number of matches has occurred. It sits between a test or host interface and the serial bit stream, replacing the fixed-pattern detectors with one run-time-configured block.

## Interface
- PLEN, 4, pattern length in bits; legal range 2..8
- CNT_W, 8, width of match target and match counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces IDLE and clears all outputs
- start  in  1  one-cycle request; honoured only in IDLE
- abort  in  1  forces return to IDLE from ARM/RUN on next edge
- pattern  in  PLEN  pattern to detect; MSB is the first bit received; latched on accepted start
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; latched on accepted start
- target  in  CNT_W  number of matches to completion; 0 = run until abort; latched on accepted start
- PI  in  1  serial data bit
- pi_valid  in  1  PI qualifier; bit consumed only when high in RUN
- PO  out  1  registered one-cycle match pulse
- busy  out  1  high in ARM and RUN
- done  out  1  one-cycle pulse when target reached
- match_cnt  out  CNT_W  matches in current/last run; holds until next accepted start

## Operation
- State machine: IDLE, ARM, RUN, DONE.
- IDLE: busy=0. If start=1, latch pattern/overlap/target, clear history, fill count and match_cnt, then go to ARM. pi_valid is ignored in IDLE.
- ARM: lasts one cycle; any PI input is ignored. Go to RUN, or to IDLE if abort=1.
- RUN, on each pi_valid=1:
  - hist_next = {hist[PLEN-2:0], PI}.
  - fill_next = min(fill+1, PLEN).
  - A match occurs when fill_next==PLEN and hist_next==latched pattern.
- On a match:
  - PO=1 on the next cycle and match_cnt increments.
  - If overlap=0, the fill count clears to 0, so the bits of the matched pattern cannot start a new match. If overlap=1, the fill count is retained.
- If the match brings match_cnt to target (target≠0), go to DONE.
- With target=0, match_cnt saturates at 2^CNT_W−1 with no wrap. PO still pulses on every match.
- pi_valid=0 in RUN: no shift, no count change. The history is preserved across gaps.
- abort in RUN: go to IDLE on the next edge. match_cnt holds its value. No PO or done is generated for a bit presented in the abort cycle.
- DONE: lasts one cycle, with done=1. Then go to IDLE.
- start is ignored while busy or in DONE.
- abort is ignored in IDLE and DONE.
- If abort and the completing match occur in the same cycle, abort wins: go to IDLE, with no PO and no done.
- reset at any time:
  - next state IDLE.
  - PO=0, busy=0, done=0, match_cnt=0.
  - History, fill count and latched configuration cleared.

## Timing
- Reset values: PO=0, busy=0, done=0, match_cnt=0, state IDLE.
- start sampled at edge k: ARM for the cycle after edge k, busy=1 from edge k. RUN from edge k+1, and the first consumable bit is sampled at edge k+2.
- Match latency: PO rises one cycle after the edge that samples the completing bit, and lasts exactly one cycle. match_cnt updates in the same cycle PO rises.
- done is asserted in the same cycle as the final PO. busy drops in that same cycle.
- Back-to-back matches (overlap=1, pattern 11, stream 111) produce PO on consecutive valid bits.
- All outputs are registered. No combinational path from PI to PO.

## Test plan
- Non-overlap: pattern=1011, overlap=0, target=0, stream 1011011 with pi_valid always high → PO pulses once, after bit 4; match_cnt=1.
- Overlap with completion: pattern=1011, overlap=1, target=2, stream 1011011 → PO after bits 4 and 7; done coincides with the second PO; match_cnt=2; busy=0 afterwards; IDLE the cycle after.
- Valid gaps: same as the overlap case, with pi_valid=0 for 3 cycles between each bit → identical PO count and match_cnt=2; PO timing is tied to valid bits only.
- Start while busy and abort: start pulses in RUN → no effect on latched config. abort after bit 3 of 1011 → IDLE; a 4th bit of 1 produces no PO; match_cnt=0 holds.
- Reset mid-run: pattern=11, overlap=1, after 2 matches assert reset for one cycle → next cycle all outputs 0, state IDLE; a subsequent start plus stream 11 yields match_cnt=1.
- Saturation: CNT_W=2, pattern=11, overlap=1, target=0, 8 ones → PO pulses 7 times; match_cnt sticks at 3; no done.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time programmable serial pattern detector with match
//   counting, overlapping or non-overlapping detection, and completion at a
//   programmed match count.
// Latency: PO/match_cnt/done appear one cycle after the edge that samples the
//   completing bit; the first consumable bit is sampled two edges after start.
// Backpressure: none; bits are consumed only while pi_valid=1 in RUN, and
//   start is ignored unless the controller is idle.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-high reset
//   start      one-cycle request, accepted only in IDLE
//   abort      return to IDLE from ARM/RUN
//   pattern    pattern to detect, MSB received first (latched on start)
//   overlap    1 = overlapping matches allowed (latched on start)
//   target     matches to completion, 0 = run until abort (latched on start)
//   PI         serial data bit
//   pi_valid   PI qualifier
//   PO         registered one-cycle match pulse
//   busy       high while in ARM or RUN
//   done       one-cycle pulse when the target count is reached
//   match_cnt  matches in the current/last run, saturating
module seq_det_ctrl #(
  parameter int PLEN  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PLEN-1:0]  pattern,
  input  logic             overlap,
  input  logic [CNT_W-1:0] target,
  input  logic             PI,
  input  logic             pi_valid,
  output logic             PO,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Fill count runs 0..PLEN, so it needs enough bits to hold PLEN itself.
  localparam int                FILL_W    = $clog2(PLEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PLEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state, state_nxt;
  logic [PLEN-1:0]   hist, hist_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic [PLEN-1:0]   pat_q, pat_nxt;
  logic              ovl_q, ovl_nxt;
  logic [CNT_W-1:0]  tgt_q, tgt_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              po_nxt, busy_nxt, done_nxt;

  // Candidate values for a consumed bit, evaluated every cycle and only
  // committed by the FSM when a bit is actually taken in RUN.
  logic [PLEN-1:0]   hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic              is_match;

  always_comb begin
    hist_shift = {hist[PLEN-2:0], PI};
    fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    // Saturate rather than wrap so a free-running (target=0) count never
    // appears to restart.
    cnt_inc    = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + CNT_W'(1);
    // A match needs PLEN bits gathered since the run began (or since the
    // last match in non-overlapping mode), not just a matching shift reg.
    is_match   = (fill_inc == FILL_FULL) && (hist_shift == pat_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    pat_nxt   = pat_q;
    ovl_nxt   = ovl_q;
    tgt_nxt   = tgt_q;
    cnt_nxt   = match_cnt;
    po_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pat_nxt   = pattern;
          ovl_nxt   = overlap;
          tgt_nxt   = target;
          hist_nxt  = '0;
          fill_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = ARM;
        end
      end

      ARM: begin
        // PI is deliberately not looked at here.
        state_nxt = abort ? IDLE : RUN;
      end

      RUN: begin
        // abort takes priority over any bit presented in the same cycle,
        // including one that would complete the run.
        if (abort) begin
          state_nxt = IDLE;
        end else if (pi_valid) begin
          hist_nxt = hist_shift;
          fill_nxt = fill_inc;
          if (is_match) begin
            po_nxt  = 1'b1;
            cnt_nxt = cnt_inc;
            // Non-overlapping: the bits just matched may not be reused, so
            // the next match needs a fresh PLEN bits.
            if (!ovl_q) begin
              fill_nxt = '0;
            end
            if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
              state_nxt = DONE;
            end
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state so they line up
    // with the state they describe.
    busy_nxt = (state_nxt == ARM) || (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      pat_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
      match_cnt <= '0;
      PO        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      pat_q     <= pat_nxt;
      ovl_q     <= ovl_nxt;
      tgt_q     <= tgt_nxt;
      match_cnt <= cnt_nxt;
      PO        <= po_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: drives two detector instances (4-bit pattern / 8-bit count
//   and 2-bit pattern / 2-bit count) with directed and random stimulus and
//   compares every output each cycle against a bit-list reference model.
module tb_seq_det_ctrl;

  localparam int AP = 4;
  localparam int AW = 8;
  localparam int BP = 2;
  localparam int BW = 2;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_start, a_abort, a_overlap, a_pi, a_pv;
  logic [AP-1:0] a_pattern;
  logic [AW-1:0] a_target;
  logic          a_po, a_busy, a_done;
  logic [AW-1:0] a_cnt;

  logic          b_reset, b_start, b_abort, b_overlap, b_pi, b_pv;
  logic [BP-1:0] b_pattern;
  logic [BW-1:0] b_target;
  logic          b_po, b_busy, b_done;
  logic [BW-1:0] b_cnt;

  seq_det_ctrl #(.PLEN(AP), .CNT_W(AW)) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .abort(a_abort),
    .pattern(a_pattern), .overlap(a_overlap), .target(a_target),
    .PI(a_pi), .pi_valid(a_pv),
    .PO(a_po), .busy(a_busy), .done(a_done), .match_cnt(a_cnt)
  );

  seq_det_ctrl #(.PLEN(BP), .CNT_W(BW)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .abort(b_abort),
    .pattern(b_pattern), .overlap(b_overlap), .target(b_target),
    .PI(b_pi), .pi_valid(b_pv),
    .PO(b_po), .busy(b_busy), .done(b_done), .match_cnt(b_cnt)
  );

  int checks = 0;
  int errors = 0;
  int a_po_seen = 0, a_done_seen = 0;
  int b_po_seen = 0, b_done_seen = 0;

  // Reference model: per instance, the list of usable bits gathered so far
  // (most recent last), plus the latched run configuration.
  int m_mode[2];
  int m_cnt[2];
  int m_pat[2];
  int m_tgt[2];
  int m_hlen[2];
  int m_h[2][8];
  bit m_ov[2];
  bit m_po[2];
  bit m_done[2];

  task automatic model_step(input int id, input int plen, input int cmax,
                            input bit rst, input bit st, input bit ab,
                            input int pat, input bit ov, input int tgt,
                            input bit pi, input bit pv);
    int v;
    m_po[id]   = 1'b0;
    m_done[id] = 1'b0;
    if (rst) begin
      m_mode[id] = M_IDLE;
      m_cnt[id]  = 0;
      m_hlen[id] = 0;
      m_pat[id]  = 0;
      m_tgt[id]  = 0;
      m_ov[id]   = 1'b0;
    end else if (m_mode[id] == M_IDLE) begin
      if (st) begin
        m_pat[id]  = pat;
        m_ov[id]   = ov;
        m_tgt[id]  = tgt;
        m_hlen[id] = 0;
        m_cnt[id]  = 0;
        m_mode[id] = M_ARM;
      end
    end else if (m_mode[id] == M_ARM) begin
      m_mode[id] = ab ? M_IDLE : M_RUN;
    end else if (m_mode[id] == M_RUN) begin
      if (ab) begin
        m_mode[id] = M_IDLE;
      end else if (pv) begin
        // keep only the newest plen bits
        if (m_hlen[id] == plen) begin
          for (int i = 0; i < plen - 1; i++) m_h[id][i] = m_h[id][i+1];
        end else begin
          m_hlen[id]++;
        end
        m_h[id][m_hlen[id]-1] = int'(pi);
        if (m_hlen[id] == plen) begin
          v = 0;
          for (int i = 0; i < plen; i++) v = v * 2 + m_h[id][i];
          if (v == m_pat[id]) begin
            m_po[id] = 1'b1;
            if (m_cnt[id] < cmax) m_cnt[id]++;
            if (!m_ov[id]) m_hlen[id] = 0;
            if (m_tgt[id] != 0 && m_cnt[id] == m_tgt[id]) begin
              m_mode[id] = M_DONE;
              m_done[id] = 1'b1;
            end
          end
        end
      end
    end else begin
      m_mode[id] = M_IDLE;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs currently applied, then
  // compare every output of both instances just after the edge.
  task automatic step();
    model_step(0, AP, (1 << AW) - 1, a_reset, a_start, a_abort, int'(a_pattern),
               a_overlap, int'(a_target), a_pi, a_pv);
    model_step(1, BP, (1 << BW) - 1, b_reset, b_start, b_abort, int'(b_pattern),
               b_overlap, int'(b_target), b_pi, b_pv);
    @(posedge clk);
    #1;
    chk("a_po",   32'(a_po),   int'(m_po[0]));
    chk("a_done", 32'(a_done), int'(m_done[0]));
    chk("a_busy", 32'(a_busy), int'(m_mode[0] == M_ARM || m_mode[0] == M_RUN));
    chk("a_cnt",  32'(a_cnt),  m_cnt[0]);
    chk("b_po",   32'(b_po),   int'(m_po[1]));
    chk("b_done", 32'(b_done), int'(m_done[1]));
    chk("b_busy", 32'(b_busy), int'(m_mode[1] == M_ARM || m_mode[1] == M_RUN));
    chk("b_cnt",  32'(b_cnt),  m_cnt[1]);
    if (a_po === 1'b1)   a_po_seen++;
    if (a_done === 1'b1) a_done_seen++;
    if (b_po === 1'b1)   b_po_seen++;
    if (b_done === 1'b1) b_done_seen++;
  endtask

  task automatic a_go(input int pat, input bit ov, input int tgt);
    a_pattern = AP'(pat);
    a_overlap = ov;
    a_target  = AW'(tgt);
    a_start   = 1'b1;
    step();
    a_start   = 1'b0;
    step();
    a_po_seen   = 0;
    a_done_seen = 0;
  endtask

  task automatic b_go(input int pat, input bit ov, input int tgt);
    b_pattern = BP'(pat);
    b_overlap = ov;
    b_target  = BW'(tgt);
    b_start   = 1'b1;
    step();
    b_start   = 1'b0;
    step();
    b_po_seen   = 0;
    b_done_seen = 0;
  endtask

  // Feed n bits of v, MSB first, with 'gap' invalid cycles after each bit.
  task automatic a_bits(input int v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      a_pi = v[i];
      a_pv = 1'b1;
      step();
      a_pv = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic b_bits(input int v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      b_pi = v[i];
      b_pv = 1'b1;
      step();
      b_pv = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic a_abort_now();
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
  endtask

  task automatic b_abort_now();
    b_abort = 1'b1;
    step();
    b_abort = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_overlap = 1'b0;
    a_pi = 1'b0; a_pv = 1'b0; a_pattern = '0; a_target = '0;
    b_reset = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_overlap = 1'b0;
    b_pi = 1'b0; b_pv = 1'b0; b_pattern = '0; b_target = '0;

    // reset state
    step();
    step();
    chk("rst_a_cnt", 32'(a_cnt), 0);
    chk("rst_a_busy", 32'(a_busy), 0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    step();

    // non-overlapping, free running
    a_go(4'b1011, 1'b0, 0);
    a_bits(7'b1011011, 7, 0);
    chk("nonovl_po_count", 32'(a_po_seen), 1);
    chk("nonovl_cnt", 32'(a_cnt), 1);
    a_abort_now();
    chk("nonovl_cnt_hold", 32'(a_cnt), 1);

    // overlapping with completion at 2
    a_go(4'b1011, 1'b1, 2);
    a_bits(7'b1011011, 7, 0);
    chk("ovl_done_with_po", 32'(a_done & a_po), 1);
    chk("ovl_busy_at_done", 32'(a_busy), 0);
    step();
    chk("ovl_po_count", 32'(a_po_seen), 2);
    chk("ovl_done_count", 32'(a_done_seen), 1);
    chk("ovl_cnt", 32'(a_cnt), 2);
    chk("ovl_idle_done", 32'(a_done), 0);

    // same with valid gaps
    a_go(4'b1011, 1'b1, 2);
    a_bits(7'b1011011, 7, 3);
    chk("gap_po_count", 32'(a_po_seen), 2);
    chk("gap_done_count", 32'(a_done_seen), 1);
    chk("gap_cnt", 32'(a_cnt), 2);

    // start while busy must not disturb the latched configuration
    a_go(4'b1011, 1'b1, 0);
    a_pattern = 4'b0000;
    a_overlap = 1'b0;
    a_target  = 8'd1;
    a_start   = 1'b1;
    step();
    a_start   = 1'b0;
    a_bits(4'b1011, 4, 0);
    chk("busy_start_po_count", 32'(a_po_seen), 1);
    chk("busy_start_still_busy", 32'(a_busy), 1);
    a_abort_now();

    // abort with the completing bit presented in the same cycle
    a_go(4'b1011, 1'b0, 1);
    a_bits(3'b101, 3, 0);
    a_pi = 1'b1; a_pv = 1'b1; a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    step();
    a_pv = 1'b0;
    chk("abort_po_count", 32'(a_po_seen), 0);
    chk("abort_done_count", 32'(a_done_seen), 0);
    chk("abort_cnt", 32'(a_cnt), 0);
    chk("abort_busy", 32'(a_busy), 0);

    // reset mid-run on the small instance
    b_go(2'b11, 1'b1, 0);
    b_bits(3'b111, 3, 0);
    chk("b_pre_reset_cnt", 32'(b_cnt), 2);
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    chk("b_rst_po", 32'(b_po), 0);
    chk("b_rst_busy", 32'(b_busy), 0);
    chk("b_rst_cnt", 32'(b_cnt), 0);
    b_go(2'b11, 1'b1, 0);
    b_bits(2'b11, 2, 0);
    chk("b_after_rst_cnt", 32'(b_cnt), 1);
    b_abort_now();

    // saturation at 3 with back-to-back overlapping matches
    b_go(2'b11, 1'b1, 0);
    b_bits(8'hFF, 8, 0);
    chk("sat_po_count", 32'(b_po_seen), 7);
    chk("sat_cnt", 32'(b_cnt), 3);
    chk("sat_no_done", 32'(b_done_seen), 0);
    b_abort_now();

    // random traffic on both instances
    repeat (800) begin
      a_reset = ($urandom_range(0, 149) == 0);
      a_start = ($urandom_range(0, 7) == 0);
      a_abort = ($urandom_range(0, 39) == 0);
      a_pv    = ($urandom_range(0, 3) != 0);
      a_pi    = 1'($urandom_range(0, 1));
      if (a_start) begin
        a_pattern = AP'($urandom_range(0, 15));
        a_overlap = 1'($urandom_range(0, 1));
        a_target  = AW'($urandom_range(0, 4));
      end
      b_reset = ($urandom_range(0, 149) == 0);
      b_start = ($urandom_range(0, 7) == 0);
      b_abort = ($urandom_range(0, 39) == 0);
      b_pv    = ($urandom_range(0, 3) != 0);
      b_pi    = 1'($urandom_range(0, 1));
      if (b_start) begin
        b_pattern = BP'($urandom_range(0, 3));
        b_overlap = 1'($urandom_range(0, 1));
        b_target  = BW'($urandom_range(0, 3));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
